// File: rtl/message_packer.sv
// message_packer: buffers up to MAX_MSGS byte-masked messages and streams them as one 64-bit Avalon-ST packet.
// Optional build macro MESSAGE_PACKER_ZERO_LEN_DROP_EN: discard zero-length messages instead of emitting them.
module message_packer #(
  parameter int MAX_MSGS  = 16,
  parameter int MSG_BYTES = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_data,
  input  logic [31:0]  in_bytemask,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data,
  output logic         out_startofpacket,
  output logic         out_endofpacket,
  output logic [2:0]   out_empty,
  output logic         out_error
);

  localparam int SEG_MAX = MSG_BYTES + 2;
  localparam int B_MAX   = 2 + MAX_MSGS * SEG_MAX;
  localparam int DEPTH   = (B_MAX + 7) / 8 + 6;
  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = $clog2(MAX_MSGS + 1);

  typedef enum logic {S_COLLECT, S_EMIT} state_t;

  state_t        r_state;
  logic          r_in_ready;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_wr_pos;
  logic [AW-1:0] r_rd_word;
  logic [AW-1:0] r_last_word;
  logic [2:0]    r_empty;
  logic          r_out_valid;
  logic [63:0]   r_out_data;
  logic          r_out_sop;
  logic          r_out_eop;
  logic [2:0]    r_out_empty;

  // Packet image laid out exactly as it goes on the wire; header bytes 0..1 are patched on read.
  logic [63:0]   r_mem [DEPTH];

  logic          w_accept;
  logic          w_store;
  logic [5:0]    w_len;
  logic [6:0]    w_seg_n;
  logic [271:0]  w_seg;
  logic [33:0]   w_seg_mask;
  logic [383:0]  w_shift_data;
  logic [47:0]   w_shift_be;
  logic [63:0]   w_lane_data [6];
  logic [7:0]    w_lane_be   [6];
  logic [AW-1:0] w_lane_addr [6];
  logic [63:0]   w_be0_bits;
  logic          w_lane0_hit;
  logic [63:0]   w_word0;
  logic [63:0]   w_first;
  logic [CW-1:0] w_cnt_next;
  logic          w_close;
  logic [15:0]   w_b_next;
  logic [15:0]   w_words;
  logic          w_single;
  logic [2:0]    w_empty_next;

  assign in_ready          = r_in_ready;
  assign out_valid         = r_out_valid;
  assign out_data          = r_out_data;
  assign out_startofpacket = r_out_sop;
  assign out_endofpacket   = r_out_eop;
  assign out_empty         = r_out_empty;
  assign out_error         = 1'b0;

  assign w_accept = in_valid & r_in_ready;

`ifdef MESSAGE_PACKER_ZERO_LEN_DROP_EN
  assign w_store = (in_bytemask != 32'd0);
`else
  assign w_store = 1'b1;
`endif

  always_comb begin
    w_len = '0;
    for (int i = 0; i < 32; i++) begin
      w_len = w_len + {5'd0, in_bytemask[i]};
    end
  end

  // A message becomes a segment {len16, payload}; only its first 2+len bytes are written.
  assign w_seg_n      = {1'b0, w_len} + 7'd2;
  assign w_seg        = {10'd0, w_len, in_data};
  assign w_seg_mask   = ~({34{1'b1}} >> w_seg_n);
  assign w_shift_data = {w_seg, 112'd0} >> {r_wr_pos[2:0], 3'b000};
  assign w_shift_be   = {w_seg_mask, 14'd0} >> r_wr_pos[2:0];

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_lane
      assign w_lane_data[gi] = w_shift_data[383-64*gi -: 64];
      assign w_lane_be[gi]   = w_shift_be[47-8*gi -: 8];
      assign w_lane_addr[gi] = AW'(r_wr_pos >> 3) + AW'(gi);
    end
    for (gi = 0; gi < 8; gi++) begin : g_be0
      assign w_be0_bits[63-8*gi -: 8] = {8{w_lane_be[0][7-gi]}};
    end
  endgenerate

  // The closing message may land in word 0, which is read in the same cycle.
  assign w_lane0_hit = w_store && (r_wr_pos[15:3] == 13'd0);
  assign w_word0     = w_lane0_hit ? ((r_mem[0] & ~w_be0_bits) | (w_lane_data[0] & w_be0_bits))
                                   : r_mem[0];
  assign w_cnt_next  = r_cnt + CW'(w_store);
  assign w_first     = {16'(w_cnt_next), w_word0[47:0]};

  assign w_close      = in_last | (w_store & (w_cnt_next == CW'(MAX_MSGS)));
  assign w_b_next     = r_wr_pos + (w_store ? {9'd0, w_seg_n} : 16'd0);
  assign w_words      = (w_b_next + 16'd7) >> 3;
  assign w_single     = (w_words == 16'd1);
  assign w_empty_next = 3'd0 - w_b_next[2:0];

  function automatic logic [63:0] tail_mask(input logic [63:0] d, input logic [2:0] e);
    return d & ({64{1'b1}} << {e, 3'b000});
  endfunction

  always_ff @(posedge clk) begin
    if (w_accept && w_store) begin
      for (int k = 0; k < 6; k++) begin
        for (int b = 0; b < 8; b++) begin
          if (w_lane_be[k][7-b]) begin
            r_mem[w_lane_addr[k]][8*(7-b) +: 8] <= w_lane_data[k][8*(7-b) +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_COLLECT;
      r_in_ready  <= 1'b0;
      r_cnt       <= '0;
      r_wr_pos    <= 16'd2;
      r_rd_word   <= '0;
      r_last_word <= '0;
      r_empty     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_empty <= '0;
    end else begin
      case (r_state)
        S_COLLECT: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            if (w_close && (w_cnt_next != '0)) begin
              r_state     <= S_EMIT;
              r_in_ready  <= 1'b0;
              r_cnt       <= w_cnt_next;
              r_wr_pos    <= w_b_next;
              r_rd_word   <= AW'(1);
              r_last_word <= AW'(w_words - 16'd1);
              r_empty     <= w_empty_next;
              r_out_valid <= 1'b1;
              r_out_sop   <= 1'b1;
              r_out_eop   <= w_single;
              r_out_data  <= w_single ? tail_mask(w_first, w_empty_next) : w_first;
              r_out_empty <= w_single ? w_empty_next : 3'd0;
            end else if (w_close) begin
              r_cnt    <= '0;
              r_wr_pos <= 16'd2;
            end else begin
              r_cnt    <= w_cnt_next;
              r_wr_pos <= w_b_next;
            end
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            if (r_out_eop) begin
              r_state     <= S_COLLECT;
              r_in_ready  <= 1'b1;
              r_cnt       <= '0;
              r_wr_pos    <= 16'd2;
              r_out_valid <= 1'b0;
              r_out_sop   <= 1'b0;
              r_out_eop   <= 1'b0;
              r_out_data  <= '0;
              r_out_empty <= '0;
            end else begin
              r_out_sop <= 1'b0;
              r_rd_word <= r_rd_word + AW'(1);
              if (r_rd_word == r_last_word) begin
                r_out_eop   <= 1'b1;
                r_out_data  <= tail_mask(r_mem[r_rd_word], r_empty);
                r_out_empty <= r_empty;
              end else begin
                r_out_data  <= r_mem[r_rd_word];
              end
            end
          end
        end
        default: r_state <= S_COLLECT;
      endcase
    end
  end

endmodule
